// File: rtl/uc_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uc_mc_pkg
// Description : Shared types and constants for the multicycle MIPS control
//               unit: state encoding, opcodes, ALU and mux select codes, and
//               the DECODE dispatch function. The BRANCH_NE dispatch is only
//               compiled when UC_BNE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package uc_mc_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEMADR    = 4'd3,
        S_MEMRD     = 4'd4,
        S_MEMWB     = 4'd5,
        S_MEMWR     = 4'd6,
        S_EXEC      = 4'd7,
        S_ALUWB     = 4'd8,
        S_ADDIEX    = 4'd9,
        S_ADDIWB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_BRANCH_NE = 4'd13
    } uc_state_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // State following DECODE; S_FETCH means the opcode is undefined.
    function automatic uc_state_t decode_next(input logic [OPC_W-1:0] op);
        uc_state_t nxt;
        case (op)
            OP_RTYPE:     nxt = S_EXEC;
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_BEQ:       nxt = S_BRANCH;
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JUMP;
`ifdef UC_BNE_EN
            OP_BNE:       nxt = S_BRANCH_NE;
`endif
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uc_retire_counter.sv
`default_nettype none
// ============================================================================
// Module      : uc_retire_counter
// Description : Retired-instruction counter with enable and asynchronous
//               active-low clear; wraps modulo 2^CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count one per enabled edge; natural overflow gives the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_multiciclo
// Description : Moore FSM control unit for the multicycle MIPS datapath with
//               memory-ready stalls, illegal-opcode flag and retired
//               instruction counter. Define UC_BNE_EN to add bne support
//               (BRANCH_NE state and branchNe output).
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_multiciclo
    import uc_mc_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] operacao,
    input  logic                mem_ready,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic                iorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                memtoReg,
    output logic                regDst,
    output logic                regWrite,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [1:0]          aluOp,
    output logic [1:0]          pcSource,
    output logic                illegal,
`ifdef UC_BNE_EN
    output logic                branchNe,
`endif
    output logic [CNT_W-1:0]    instr_count
);

    uc_state_t r_state;
    uc_state_t w_next;
    uc_state_t w_dec_next;
    logic      r_is_store;
    logic      w_retire;

    assign w_dec_next = decode_next(operacao);

    // State register; lw/sw choice is captured in DECODE so the opcode is
    // not needed again in MEMADR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RESET;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_is_store <= (operacao == OP_SW);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_RESET:     w_next = S_FETCH;
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    w_next = w_dec_next;
            S_MEMADR:    w_next = r_is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD:     w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:     w_next = S_FETCH;
            S_MEMWR:     w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:      w_next = S_ALUWB;
            S_ALUWB:     w_next = S_FETCH;
            S_ADDIEX:    w_next = S_ADDIWB;
            S_ADDIWB:    w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
`ifdef UC_BNE_EN
            S_BRANCH_NE: w_next = S_FETCH;
`endif
            default:     w_next = S_FETCH;
        endcase
    end

    // Moore outputs decoded from the state; only FETCH writes and the MEMWR
    // retire look at mem_ready.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memtoReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_REG;
        aluOp       = ALUOP_ADD;
        pcSource    = PCSRC_ALU;
        illegal     = 1'b0;
        w_retire    = 1'b0;
`ifdef UC_BNE_EN
        branchNe    = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                irWrite = mem_ready;
                pcWrite = mem_ready;
            end
            S_DECODE: begin
                aluSrcB = SRCB_BRANCH;
                illegal = (w_dec_next == S_FETCH);
            end
            S_MEMADR, S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                iorD    = 1'b1;
                memRead = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memtoReg = 1'b1;
                w_retire = 1'b1;
            end
            S_MEMWR: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
                w_retire = mem_ready;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                w_retire = 1'b1;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
                w_retire    = 1'b1;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = PCSRC_JUMP;
                w_retire = 1'b1;
            end
`ifdef UC_BNE_EN
            S_BRANCH_NE: begin
                aluSrcA     = 1'b1;
                aluOp       = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
                branchNe    = 1'b1;
                w_retire    = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    uc_retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_retire),
        .o_count (instr_count)
    );

endmodule
`default_nettype wire
